hazard_control_unit: RTL

Pipeline sequencing controller for the 5-stage RISC-V core, sitting beside the operand forwarding logic in the ID/EX boundary region. It covers the hazards forwarding cannot resolve:
- **Load-use:** inserts a one-cycle bubble.
- **Taken branch/jump:** flushes the two younger stages.
- **Multi-cycle MUL/DIV in EX:** holds the front of the pipeline for a fixed latency while draining bubbles into MEM.

It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hazard_control_unit_sat_counter.sv | 28 ++
 rtl/hazard_control_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================
// hazard_pkg : shared types and control constants for the hazard unit
// Rev 1.0
// ============================================================
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hazard_state_t;

  localparam int MD_LATENCY_DEF = 4;
  localparam int CNT_W_DEF      = 32;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } hazard_ctl_t;

  localparam hazard_ctl_t CTL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                         if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0};
  localparam hazard_ctl_t CTL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1};
  localparam hazard_ctl_t CTL_LOAD_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b1,
                                              if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};
  localparam hazard_ctl_t CTL_MD_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b1};
  localparam hazard_ctl_t CTL_BRANCH_FLUSH = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                               if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b0};

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_sat_counter.sv
`default_nettype none
// ============================================================
// sat_counter : CNT_W-bit saturating event counter, async active-low clear
// Rev 1.0
// ============================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================
// hazard_control_unit : load-use bubble, branch flush and MUL/DIV hold control
// Rev 1.0
// ============================================================
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MulDiv,
  input  logic             branch_taken,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MD_CNT_W = $clog2(MD_LATENCY) + 1;
  localparam int MD_LOAD  = (MD_LATENCY > 2) ? (MD_LATENCY - 2) : 0;
  localparam bit MD_EN    = (MD_LATENCY > 1);
  localparam bit MD_MULTI = (MD_LATENCY > 2);

  hazard_state_t       r_state;
  hazard_state_t       w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic [MD_CNT_W-1:0] w_md_cnt_nxt;
  hazard_ctl_t         w_ctl;
  logic                w_md_busy;
  logic                w_load_use;
  logic                w_md_start;
  logic                w_stall_inc;
  logic                w_flush_inc;

  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
  assign w_md_start = ID_EX_MulDiv && MD_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // r_md_cnt holds the MD_BUSY cycles still to come, including the current one;
  // the start cycle itself is the first of the MD_LATENCY-1 hold cycles.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_ctl        = CTL_NORMAL;
    w_md_busy    = 1'b0;
    w_flush_inc  = 1'b0;
    if (!rst_n) begin
      w_ctl = CTL_RESET;
    end else begin
      case (r_state)
        RUN: begin
          if (branch_taken) begin
            w_ctl       = CTL_BRANCH_FLUSH;
            w_flush_inc = 1'b1;
          end else if (w_md_start) begin
            w_ctl     = CTL_MD_HOLD;
            w_md_busy = 1'b1;
            if (MD_MULTI) begin
              w_state_nxt  = MD_BUSY;
              w_md_cnt_nxt = MD_CNT_W'(MD_LOAD);
            end
          end else if (w_load_use) begin
            w_ctl = CTL_LOAD_BUBBLE;
          end
        end
        MD_BUSY: begin
          w_ctl        = CTL_MD_HOLD;
          w_md_busy    = 1'b1;
          w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
          if (r_md_cnt <= MD_CNT_W'(1)) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  assign w_stall_inc = !w_ctl.pc_write;

  assign PCWrite      = w_ctl.pc_write;
  assign IF_ID_Write  = w_ctl.if_id_write;
  assign ID_EX_Write  = w_ctl.id_ex_write;
  assign IF_ID_Flush  = w_ctl.if_id_flush;
  assign ID_EX_Flush  = w_ctl.id_ex_flush;
  assign EX_MEM_Flush = w_ctl.ex_mem_flush;
  assign md_busy      = w_md_busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall_inc),
    .o_count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_flush_inc),
    .o_count (flush_count)
  );

endmodule
`default_nettype wire
